// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write scheduler.
// rf_wr_t is one queued write: destination register plus value.
package rf_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

    localparam logic [RF_ADDR_W-1:0] RF_ZERO_REG = '0;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } rf_wr_t;

endpackage

// File: rtl/rf_drdw_intf.sv
// Dual-read/dual-write register-file interface.
// The scheduler drives it through to_rf; the register file sits on from_rf.
interface rf_drdw_intf
    import rf_pkg::*;
#(
    parameter int addr_w = RF_ADDR_W,
    parameter int data_w = RF_DATA_W
);

    logic [addr_w-1:0] Rd1Addr;
    logic [data_w-1:0] Rd1Data;
    logic [addr_w-1:0] Rd2Addr;
    logic [data_w-1:0] Rd2Data;
    logic [addr_w-1:0] Rs1Addr;
    logic [addr_w-1:0] Rs2Addr;
    logic [data_w-1:0] Rs1Data;
    logic [data_w-1:0] Rs2Data;

    modport to_rf (
        output Rd1Addr, Rd1Data, Rd2Addr, Rd2Data, Rs1Addr, Rs2Addr,
        input  Rs1Data, Rs2Data
    );

    modport from_rf (
        input  Rd1Addr, Rd1Data, Rd2Addr, Rd2Data, Rs1Addr, Rs2Addr,
        output Rs1Data, Rs2Data
    );

endinterface

// File: rtl/rf_fwd_lookup.sv
// Youngest-match search over the live part of the write queue for one read
// address; falls back to the register-file value, and x0 always reads zero.
module rf_fwd_lookup
    import rf_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  rf_wr_t               i_q [DEPTH],
    input  logic [PTR_W-1:0]     i_head,
    input  logic [CNT_W-1:0]     i_count,
    input  logic [RF_ADDR_W-1:0] i_addr,
    input  logic [RF_DATA_W-1:0] i_rf_data,
    output logic [RF_DATA_W-1:0] o_data
);

    // Walking from head towards tail lets each later (younger) match override.
    always_comb begin : p_search
        logic [PTR_W-1:0] w_idx;
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and a latch is never inferred.
        o_data = i_rf_data;
        w_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = i_head + PTR_W'(i);
            if ((CNT_W'(i) < i_count) && (i_q[w_idx].addr == i_addr)) begin
                o_data = i_q[w_idx].data;
            end
        end
        if (i_addr == RF_ZERO_REG) begin
            o_data = '0;
        end
    end

endmodule

// File: rtl/rf_write_scheduler.sv
// In-order retire queue draining up to two register-file writes per cycle,
// with same-address coalescing and read forwarding from unwritten entries.
module rf_write_scheduler
    import rf_pkg::*;
#(
    parameter int addr_w = RF_ADDR_W,
    parameter int data_w = RF_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              In0Valid,
    input  logic [addr_w-1:0] In0Addr,
    input  logic [data_w-1:0] In0Data,
    input  logic              In1Valid,
    input  logic [addr_w-1:0] In1Addr,
    input  logic [data_w-1:0] In1Data,
    output logic              InReady,
    input  logic [addr_w-1:0] RdAddrA,
    input  logic [addr_w-1:0] RdAddrB,
    output logic [data_w-1:0] RdDataA,
    output logic [data_w-1:0] RdDataB,
    output logic              Empty,
    rf_drdw_intf.to_rf        RfIntf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    rf_wr_t           r_q [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             w_in_ready;
    logic             w_push0;
    logic             w_push1;
    logic [1:0]       w_push_cnt;
    logic [1:0]       w_pop_cnt;
    logic [PTR_W-1:0] w_next;
    logic [PTR_W-1:0] w_slot1;
    rf_wr_t           w_wr1;
    rf_wr_t           w_wr2;

    // Credit only the registered count so InReady never depends on this cycle's drain.
    assign w_in_ready = (r_count <= CNT_W'(DEPTH - 2));
    assign w_push0    = In0Valid & w_in_ready;
    assign w_push1    = In1Valid & w_in_ready;
    assign w_push_cnt = {1'b0, w_push0} + {1'b0, w_push1};
    assign w_next     = r_head + PTR_W'(1);
    assign w_slot1    = r_tail + PTR_W'(w_push0);

    // Drain the oldest one or two entries; equal addresses collapse onto the
    // younger value on Rd1. Nothing is written while reset is held.
    always_comb begin
        w_wr1     = '0;
        w_wr2     = '0;
        w_pop_cnt = 2'd0;
        if (!rst) begin
            if (r_count == CNT_W'(1)) begin
                w_wr1     = r_q[r_head];
                w_pop_cnt = 2'd1;
            end else if (r_count >= CNT_W'(2)) begin
                w_pop_cnt = 2'd2;
                if (r_q[r_head].addr == r_q[w_next].addr) begin
                    w_wr1 = r_q[w_next];
                end else begin
                    w_wr1 = r_q[r_head];
                    w_wr2 = r_q[w_next];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_pop_cnt);
            r_tail  <= r_tail + PTR_W'(w_push_cnt);
            r_count <= r_count + CNT_W'(w_push_cnt) - CNT_W'(w_pop_cnt);
        end
    end

    // NOTE: queue storage has no reset; clearing the pointers and count is what
    // discards entries, and stale slots are never read outside head..tail.
    always_ff @(posedge clk) begin
        if (w_push0) begin
            r_q[r_tail] <= '{addr: In0Addr, data: In0Data};
        end
        if (w_push1) begin
            r_q[w_slot1] <= '{addr: In1Addr, data: In1Data};
        end
    end

    rf_fwd_lookup #(.DEPTH(DEPTH)) u_fwd_a (
        .i_q       (r_q),
        .i_head    (r_head),
        .i_count   (r_count),
        .i_addr    (RdAddrA),
        .i_rf_data (RfIntf.Rs1Data),
        .o_data    (RdDataA)
    );

    rf_fwd_lookup #(.DEPTH(DEPTH)) u_fwd_b (
        .i_q       (r_q),
        .i_head    (r_head),
        .i_count   (r_count),
        .i_addr    (RdAddrB),
        .i_rf_data (RfIntf.Rs2Data),
        .o_data    (RdDataB)
    );

    assign RfIntf.Rd1Addr = w_wr1.addr;
    assign RfIntf.Rd1Data = w_wr1.data;
    assign RfIntf.Rd2Addr = w_wr2.addr;
    assign RfIntf.Rd2Data = w_wr2.data;
    assign RfIntf.Rs1Addr = RdAddrA;
    assign RfIntf.Rs2Addr = RdAddrB;

    assign InReady = w_in_ready;
    assign Empty   = (r_count == '0);

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Scoreboard bench for rf_write_scheduler: an architectural model (pending
// result list plus register values) predicts writes, flags and forwarded reads.
module tb_rf_write_scheduler;
    import rf_pkg::*;

    localparam int TB_DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        preload;
    logic        In0Valid;
    logic [4:0]  In0Addr;
    logic [31:0] In0Data;
    logic        In1Valid;
    logic [4:0]  In1Addr;
    logic [31:0] In1Data;
    logic        InReady;
    logic [4:0]  RdAddrA;
    logic [4:0]  RdAddrB;
    logic [31:0] RdDataA;
    logic [31:0] RdDataB;
    logic        Empty;

    rf_drdw_intf rf_if ();

    rf_write_scheduler #(.addr_w(5), .data_w(32), .DEPTH(TB_DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .In0Valid (In0Valid),
        .In0Addr  (In0Addr),
        .In0Data  (In0Data),
        .In1Valid (In1Valid),
        .In1Addr  (In1Addr),
        .In1Data  (In1Data),
        .InReady  (InReady),
        .RdAddrA  (RdAddrA),
        .RdAddrB  (RdAddrB),
        .RdDataA  (RdDataA),
        .RdDataB  (RdDataB),
        .Empty    (Empty),
        .RfIntf   (rf_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vectors = 0;
    int n_fail    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_val(input int i);
        case (i)
            0:       return 32'h0;
            3:       return 32'h11;
            9:       return 32'h55;
            default: return (32'(i) * 32'h0101_0101) ^ 32'h0000_C0DE;
        endcase
    endfunction

    // Physical register file attached to the interface.
    logic [31:0] rf_mem [32];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= init_val(i);
        end else begin
            if (rf_if.Rd1Addr != 5'd0) rf_mem[rf_if.Rd1Addr] <= rf_if.Rd1Data;
            if (rf_if.Rd2Addr != 5'd0) rf_mem[rf_if.Rd2Addr] <= rf_if.Rd2Data;
        end
    end
    assign rf_if.Rs1Data = rf_mem[rf_if.Rs1Addr];
    assign rf_if.Rs2Data = rf_mem[rf_if.Rs2Addr];

    // Reference model: accepted-but-unwritten results in program order, and
    // the architectural register values once those results have retired.
    rf_wr_t      pending [$];
    logic [31:0] arch [32];
    bit          arch_ready = 1'b0;

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        for (int i = pending.size() - 1; i >= 0; i--) begin
            if (pending[i].addr == a) return pending[i].data;
        end
        return arch[a];
    endfunction

    always @(negedge clk) begin : monitor
        int     n;
        int     pops;
        bit     model_ready;
        logic   rf_ok;
        rf_wr_t e1;
        rf_wr_t e2;
        rf_wr_t item;
        if (!arch_ready) begin
            for (int i = 0; i < 32; i++) arch[i] = init_val(i);
            arch_ready = 1'b1;
        end
        n           = pending.size();
        model_ready = (n <= TB_DEPTH - 2);
        e1          = '0;
        e2          = '0;
        if (!rst && n == 1) begin
            e1 = pending[0];
        end else if (!rst && n >= 2) begin
            if (pending[0].addr == pending[1].addr) begin
                e1 = pending[1];
            end else begin
                e1 = pending[0];
                e2 = pending[1];
            end
        end
        check("rd1_addr", 32'(rf_if.Rd1Addr), 32'(e1.addr));
        if (e1.addr != 5'd0) check("rd1_data", rf_if.Rd1Data, e1.data);
        check("rd2_addr", 32'(rf_if.Rd2Addr), 32'(e2.addr));
        if (e2.addr != 5'd0) check("rd2_data", rf_if.Rd2Data, e2.data);
        check("empty", 32'(Empty), 32'(n == 0));
        check("in_ready", 32'(InReady), 32'(model_ready));
        check("rs1_addr", 32'(rf_if.Rs1Addr), 32'(RdAddrA));
        check("rs2_addr", 32'(rf_if.Rs2Addr), 32'(RdAddrB));
        check("rd_data_a", RdDataA, exp_read(RdAddrA));
        check("rd_data_b", RdDataB, exp_read(RdAddrB));
        rf_ok = 1'b1;
        for (int i = 0; i < 32; i++) if (rf_mem[i] !== arch[i]) rf_ok = 1'b0;
        check("regfile", 32'(rf_ok), 32'd1);

        // Advance the model across the coming edge.
        if (rst) begin
            pending.delete();
        end else begin
            pops = (n < 2) ? n : 2;
            for (int i = 0; i < pops; i++) begin
                item = pending.pop_front();
                if (item.addr != 5'd0) arch[item.addr] = item.data;
            end
            if (model_ready && In0Valid) pending.push_back('{addr: In0Addr, data: In0Data});
            if (model_ready && In1Valid) pending.push_back('{addr: In1Addr, data: In1Data});
        end
    end

    task automatic cyc(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                       input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic [4:0] ra, input logic [4:0] rb);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        In0Valid = v0;
        In0Addr  = a0;
        In0Data  = d0;
        In1Valid = v1;
        In1Addr  = a1;
        In1Data  = d1;
        RdAddrA  = ra;
        RdAddrB  = rb;
    endtask

    task automatic idle(input int cycles, input logic [4:0] ra, input logic [4:0] rb);
        for (int i = 0; i < cycles; i++) cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ra, rb);
    endtask

    task automatic reset_cycle();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        In0Valid = 1'b0;
        In1Valid = 1'b0;
    endtask

    initial begin : driver
        rst      = 1'b1;
        preload  = 1'b1;
        In0Valid = 1'b0;
        In0Addr  = '0;
        In0Data  = '0;
        In1Valid = 1'b0;
        In1Addr  = '0;
        In1Data  = '0;
        RdAddrA  = 5'd3;
        RdAddrB  = 5'd0;
        @(posedge clk);
        #1;
        preload = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Pair to distinct registers, then a same-address pair that coalesces.
        cyc(1'b1, 5'd5, 32'hA, 1'b1, 5'd6, 32'hB, 5'd5, 5'd6);
        idle(2, 5'd5, 5'd6);
        cyc(1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2, 5'd7, 5'd0);
        idle(2, 5'd7, 5'd7);

        // Back-to-back pairs, the first pair aimed at x0.
        cyc(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF, 5'd0, 5'd0);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 5'($urandom_range(1, 15)), $urandom, 1'b1, 5'($urandom_range(1, 15)), $urandom,
                5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
        end
        idle(2, 5'd0, 5'd1);

        // Forwarding of x9 while its two results are still queued.
        cyc(1'b1, 5'd9, 32'h66, 1'b1, 5'd9, 32'h77, 5'd0, 5'd9);
        idle(2, 5'd0, 5'd9);

        // Reset while a pair is queued: both writes must be dropped.
        cyc(1'b1, 5'd11, 32'h1111, 1'b1, 5'd12, 32'h2222, 5'd11, 5'd12);
        reset_cycle();
        idle(2, 5'd11, 5'd12);

        // Random traffic with frequent address collisions.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                reset_cycle();
            end else begin
                bit gate;
                gate = InReady || ($urandom_range(0, 7) == 0);
                cyc(gate && ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
                    gate && ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            end
        end

        idle(1, 5'd0, 5'd0);
        for (int i = 0; i < 16 && Empty !== 1'b1; i++) @(posedge clk);
        #1;
        check("drain_empty", 32'(Empty), 32'd1);
        idle(2, 5'd9, 5'd7);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_fail);
        $finish;
    end

endmodule
